// File: rtl/instr_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: queue entry layout and fetch FSM states.
// Default widths match the instr_fetch_queue parameter defaults.
package instr_fetch_queue_pkg;

  localparam int unsigned IFQ_PC_W  = 9;
  localparam int unsigned IFQ_INS_W = 32;

  typedef struct packed {
    logic [IFQ_PC_W-1:0]  pc;
    logic [IFQ_INS_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle of fetch-queue signals: decode control, instruction-memory port and IF/ID output.
// master = the fetch queue, slave = the surrounding pipeline and memory.
interface instr_fetch_queue_if #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned INS_W = 32
);
  logic             stall;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ready;
  logic             imem_rsp_valid;
  logic [INS_W-1:0] imem_rsp_data;
  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_instr;

  modport master (
    input  stall, redirect, redirect_pc, imem_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req, imem_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req, imem_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer for fetched instructions: synchronous write, combinational head view,
// registered occupancy count; flush empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned  DEPTH  = 4,
  parameter int unsigned  DATA_W = 41,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty
);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = i_push && !i_flush && (r_count != FULL_CNT);
  assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are exactly PTR_W bits wide, so they wrap at DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues credit-limited fetches, buffers responses for IF/ID,
// flushes on redirect. Define FETCH_BYPASS_EN to forward responses straight to the output.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned PC_W     = IFQ_PC_W,
  parameter int unsigned INS_W    = IFQ_INS_W,
  parameter int unsigned FQ_DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_queue_if.master bus
);
  localparam int unsigned ENTRY_W = PC_W + INS_W;
  localparam int unsigned CNT_W   = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FQ_DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_inflight_pc;
  logic            r_inflight;

  logic               w_req;
  logic               w_accept;
  logic               w_rsp_take;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;
  logic               w_out_valid;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_occupancy;
  logic [PC_W-1:0]    w_redirect_pc;
  logic [ENTRY_W-1:0] w_rsp_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_out_entry;

  // Credit: a request is only issued if its response is guaranteed a free slot.
  assign w_occupancy   = w_count + CNT_W'(r_inflight);
  assign w_redirect_pc = bus.redirect_pc & ~PC_W'(3);

  assign w_req    = reset && (r_state == S_FETCH) && !bus.redirect && (w_occupancy < DEPTH_CNT);
  assign w_accept = w_req && bus.imem_ready;

  // A response is only ours if we accepted a request last cycle and nothing flushed it.
  assign w_rsp_take  = reset && r_inflight && bus.imem_rsp_valid
                       && (r_state == S_FETCH) && !bus.redirect;
  assign w_rsp_entry = {r_inflight_pc, bus.imem_rsp_data};

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_rsp_take && w_fifo_empty && !bus.stall;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_rsp_take && !w_bypass;
  assign w_pop  = reset && !w_fifo_empty && !bus.stall && !bus.redirect;

  fetch_fifo #(
    .DEPTH  (FQ_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.redirect),
    .i_push  (w_push),
    .i_data  (w_rsp_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_state_next = r_state;
    if (bus.redirect) begin
      w_state_next = r_inflight ? S_FLUSH : S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_FETCH;
        S_FETCH: w_state_next = S_FETCH;
        S_FLUSH: w_state_next = S_FETCH;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_accept;
      if (w_accept) begin
        r_inflight_pc <= r_pc;
      end
      if (bus.redirect) begin
        r_pc <= w_redirect_pc;
      end else if (w_accept) begin
        r_pc <= r_pc + PC_W'(4);
      end
    end
  end

  assign w_out_valid = reset && (!w_fifo_empty || w_bypass);
  assign w_out_entry = w_fifo_empty ? w_rsp_entry : w_head;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = reset ? r_pc : '0;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_valid ? w_out_entry[ENTRY_W-1:INS_W] : '0;
  assign bus.out_instr = w_out_valid ? w_out_entry[INS_W-1:0] : '0;

endmodule
